// File: rtl/cmp_pkg.sv
// Shared types, defaults and the round-robin pick function for cmp_rr_sched.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DEF_W = 2;
   localparam int DEF_N = 4;
   localparam int MAX_N = 8;

   // First set bit of valid at or after ptr, wrapping modulo n; ids >= n are never visited.
   function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                          input int n);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_N; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && !found && valid[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/cmp_rr_sched_if.sv
// Request/response bus between client blocks and the shared-comparator scheduler.
interface cmp_rr_sched_if
   import cmp_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int N = DEF_N
);
   localparam int IDW = $clog2(N);

   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic           rsp_eq;
   logic           rsp_gt;
   logic           rsp_lt;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt
   );

endinterface

// File: rtl/cmp_core.sv
// Unsigned magnitude comparator shared by all requesters.
module cmp_core #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         gt,
   output logic         lt
);

   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one cmp_core among N requesters.
module cmp_rr_sched
   import cmp_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int N = DEF_N
) (
   input logic           clk,
   input logic           rst,
   cmp_rr_sched_if.slave bus
);
   localparam int IDW = $clog2(N);

   state_e         state_q;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] id_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           rsp_valid_q;
   logic [IDW-1:0] rsp_id_q;
   logic           eq_q, gt_q, lt_q;

   logic [IDW-1:0] grant;
   logic           accept;
   logic [N-1:0]   ready;
   logic           eq_c, gt_c, lt_c;

   assign grant  = IDW'(rr_pick(8'(bus.req_valid), 3'(ptr_q), N));
   // Ready is only offered to a valid requester, so any offer is also a handshake.
   assign accept = (state_q == IDLE) && (|bus.req_valid);

   always_comb begin
      ready = '0;
      if (accept) ready[grant] = 1'b1;
   end

   cmp_core #(.W(W)) u_core (
      .a  (a_q),
      .b  (b_q),
      .eq (eq_c),
      .gt (gt_c),
      .lt (lt_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               a_q     <= bus.req_a[grant*W +: W];
               b_q     <= bus.req_b[grant*W +: W];
               id_q    <= grant;
               state_q <= CMP;
            end
            CMP: begin
               eq_q        <= eq_c;
               gt_q        <= gt_c;
               lt_q        <= lt_c;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: if (bus.rsp_ready) begin
               rsp_valid_q <= 1'b0;
               eq_q        <= 1'b0;
               gt_q        <= 1'b0;
               lt_q        <= 1'b0;
               ptr_q       <= (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_eq    = eq_q;
   assign bus.rsp_gt    = gt_q;
   assign bus.rsp_lt    = lt_q;

endmodule
